// File: rtl/ysyx_23060061_axil_master.sv
// ysyx_23060061_axil_master: CPU load/store port to AXI-Lite master bridge.
// Optional misaligned-access trap when YSYX_23060061_AXIL_MISALIGN_CHECK_EN is defined.
module ysyx_23060061_axil_master #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic [31:0]           req_wdata,
    input  logic                  req_signed,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);
    typedef enum logic [2:0] {IDLE, AR, R, WR, B, RESP} state_t;
    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0] size;
    logic [1:0] req_sz;
    logic sign, aw_done, w_done;
    logic accept, misalign, aw_hs, w_hs, r_hs, b_hs;
    logic [31:0] shifted, load_val;
    assign req_sz = (req_size == 2'd3) ? 2'd2 : req_size;
    assign accept = req_valid && state == IDLE;
    assign aw_hs = state == WR && !aw_done && awready;
    assign w_hs = state == WR && !w_done && wready;
    assign r_hs = state == R && rvalid;
    assign b_hs = state == B && bvalid;
    assign araddr = addr;
    assign awaddr = addr;
    assign shifted = rdata >> {addr[1:0], 3'b000};
    assign load_val = size == 2'd0 ? {{24{sign & shifted[7]}}, shifted[7:0]} :
                      size == 2'd1 ? {{16{sign & shifted[15]}}, shifted[15:0]} : shifted;
`ifdef YSYX_23060061_AXIL_MISALIGN_CHECK_EN
    assign misalign = (req_sz == 2'd1 && req_addr[0]) || (req_sz == 2'd2 && req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    // Next-state selection and state-decoded handshake outputs
    always_comb begin
        state_n = state;
        req_ready = state == IDLE;
        arvalid = state == AR;
        rready = state == R;
        awvalid = state == WR && !aw_done;
        wvalid = state == WR && !w_done;
        bready = state == B;
        resp_valid = state == RESP;
        case (state)
            IDLE: if (accept) state_n = misalign ? RESP : (req_wen ? WR : AR);
            AR: if (arready) state_n = R;
            R: if (rvalid) state_n = RESP;
            WR: if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = B;
            B: if (bvalid) state_n = RESP;
            RESP: if (resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // State register, request latch, channel completion flags and response capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            addr <= '0;
            size <= 2'd0;
            sign <= 1'b0;
            wdata <= 32'd0;
            wstrb <= 4'd0;
            aw_done <= 1'b0;
            w_done <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                addr <= req_addr;
                size <= req_sz;
                sign <= req_signed;
                wdata <= req_wdata << {req_addr[1:0], 3'b000};
                wstrb <= (req_sz == 2'd0 ? 4'b0001 : req_sz == 2'd1 ? 4'b0011 : 4'b1111) << req_addr[1:0];
                aw_done <= 1'b0;
                w_done <= 1'b0;
                resp_rdata <= 32'd0;
                resp_err <= misalign;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
            if (r_hs) begin
                resp_rdata <= load_val;
                resp_err <= rresp != 2'b00;
            end
            if (b_hs) begin
                resp_rdata <= 32'd0;
                resp_err <= bresp != 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_23060061_axil_master.sv
// tb_ysyx_23060061_axil_master: table vectors, random traffic vs. a byte-level model, and reset corner cases.
module tb_ysyx_23060061_axil_master;
    logic clk = 1'b0;
    logic rst;
    logic req_valid, req_ready, req_wen, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0] req_size;
    logic resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0] rresp, bresp;
    logic [3:0] wstrb;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wd;
        logic        sgn;
        logic [31:0] srd;
        logic [1:0]  sresp;
        int          ard;
        int          awd;
        int          wdly;
        int          rdy;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    ysyx_23060061_axil_master #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
        .req_size(req_size), .req_wdata(req_wdata), .req_signed(req_signed),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
        .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
        .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return sz == 2'd3 ? 4 : (1 << sz);
    endfunction

    function automatic logic is_mis(input logic [31:0] a, input logic [1:0] sz);
`ifdef YSYX_23060061_AXIL_MISALIGN_CHECK_EN
        int n = nbytes(sz);
        return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // Gather the addressed bytes that fall inside the word, then extend.
    function automatic logic [31:0] load_model(input logic [31:0] a, input logic [1:0] sz,
                                               input logic [31:0] d, input logic s);
        int n = nbytes(sz);
        int off = int'(a[1:0]);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < n; i++)
            if (off + i < 4) r[i*8 +: 8] = d[(off+i)*8 +: 8];
        if (s && n < 4 && r[8*n-1])
            for (int j = 8 * n; j < 32; j++) r[j] = 1'b1;
        return r;
    endfunction

    task automatic store_model(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                               output logic [3:0] strb, output logic [31:0] lanes, output logic [31:0] mask);
        int n = nbytes(sz);
        int off = int'(a[1:0]);
        strb = 4'd0;
        lanes = 32'd0;
        mask = 32'd0;
        for (int i = 0; i < n; i++)
            if (off + i < 4) begin
                strb[off+i] = 1'b1;
                lanes[(off+i)*8 +: 8] = d[i*8 +: 8];
                mask[(off+i)*8 +: 8] = 8'hFF;
            end
    endtask

    task automatic idle_slave();
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; resp_ready = 0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int ar_c = 0, aw_c = 0, w_c = 0, b_c = 0, rv_c = 0, cyc = 0, unstable = 0, ready_bad = 0;
        logic ar_d = 0, aw_d = 0, w_d = 0, r_d = 0, b_d = 0, done = 0, mis;
        logic [31:0] a_seen = 0, aw_seen = 0, wd_seen = 0, rd_seen = 0, lanes, mask;
        logic [3:0] ws_seen = 0, strb;
        logic err_seen = 0;
        mis = is_mis(v.addr, v.size);
        store_model(v.addr, v.size, v.wd, strb, lanes, mask);
        rdata = v.srd; rresp = v.sresp; bresp = v.sresp;
        @(negedge clk);
        check({tag, " req_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1; req_wen = v.wen; req_addr = v.addr; req_size = v.size;
        req_wdata = v.wd; req_signed = v.sgn;
        @(negedge clk);
        req_valid = 0;
        while (!done && cyc < 200) begin
            rvalid = ar_d && !r_d;
            if (rvalid && rready) r_d = 1;
            if (arvalid) begin
                ar_c++;
                if (ar_c == 1) a_seen = araddr; else if (araddr !== a_seen) unstable++;
            end
            arready = arvalid && (ar_c > v.ard);
            if (arready) ar_d = 1;
            bvalid = aw_d && w_d && !b_d;
            if (bvalid && bready) begin b_c++; b_d = 1; end
            if (awvalid) begin
                aw_c++;
                if (aw_c == 1) aw_seen = awaddr; else if (awaddr !== aw_seen) unstable++;
            end
            awready = awvalid && (aw_c > v.awd);
            if (awready) aw_d = 1;
            if (wvalid) begin
                w_c++;
                if (w_c == 1) begin wd_seen = wdata; ws_seen = wstrb; end
                else if (wdata !== wd_seen || wstrb !== ws_seen) unstable++;
            end
            wready = wvalid && (w_c > v.wdly);
            if (wready) w_d = 1;
            if (resp_valid) begin
                rv_c++;
                if (rv_c == 1) begin rd_seen = resp_rdata; err_seen = resp_err; end
                else if (resp_rdata !== rd_seen || resp_err !== err_seen) unstable++;
                if (req_ready) ready_bad++;
            end
            resp_ready = resp_valid && (rv_c > v.rdy);
            if (resp_ready) done = 1;
            @(negedge clk);
            cyc++;
        end
        idle_slave();
        check({tag, " completed"}, {31'd0, done}, 32'd1);
        check({tag, " req_ready_after"}, {31'd0, req_ready}, 32'd1);
        check({tag, " resp_rdata"}, rd_seen, v.exp_rdata);
        check({tag, " resp_err"}, {31'd0, err_seen}, {31'd0, v.exp_err});
        check({tag, " resp_cycles"}, rv_c, v.rdy + 1);
        check({tag, " stable"}, unstable, 0);
        check({tag, " req_ready_busy"}, ready_bad, 0);
        if (mis) check({tag, " no_axi_valid"}, ar_c + aw_c + w_c, 0);
        else if (!v.wen) begin
            check({tag, " araddr"}, a_seen, v.addr);
            check({tag, " ar_cycles"}, ar_c, v.ard + 1);
            check({tag, " no_write"}, aw_c + w_c, 0);
        end else begin
            check({tag, " awaddr"}, aw_seen, v.addr);
            check({tag, " wstrb"}, {28'd0, ws_seen}, {28'd0, strb});
            check({tag, " wdata"}, wd_seen & mask, lanes);
            check({tag, " aw_cycles"}, aw_c, v.awd + 1);
            check({tag, " w_cycles"}, w_c, v.wdly + 1);
            check({tag, " b_count"}, b_c, 1);
            check({tag, " no_read"}, ar_c, 0);
        end
    endtask

    vec_t vecs[10];
    vec_t rv;
    int bad;

    initial begin
        rst = 0;
        req_valid = 0; req_wen = 0; req_addr = 0; req_size = 0; req_wdata = 0; req_signed = 0;
        rdata = 0; rresp = 0; bresp = 0;
        idle_slave();
        //                wen  addr          sz     wd            sgn  srd           rsp    ard awd wd rdy exp_rdata     err
        vecs[0] = '{1'b0, 32'h8000_0000, 2'd2, 32'h0,         1'b0, 32'hDEAD_BEEF, 2'b00, 3, 0, 0, 0, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b0, 32'h8000_0003, 2'd0, 32'h0,         1'b1, 32'h8A00_0000, 2'b00, 0, 0, 0, 0, 32'hFFFF_FF8A, 1'b0};
        vecs[2] = '{1'b0, 32'h8000_0003, 2'd0, 32'h0,         1'b0, 32'h8A00_0000, 2'b00, 1, 0, 0, 1, 32'h0000_008A, 1'b0};
        vecs[3] = '{1'b1, 32'h8000_0002, 2'd1, 32'h0000_1234, 1'b0, 32'h0,         2'b00, 0, 2, 0, 0, 32'h0,         1'b0};
        vecs[4] = '{1'b1, 32'h8000_0000, 2'd2, 32'hA5A5_5A5A, 1'b0, 32'h0,         2'b10, 0, 0, 1, 5, 32'h0,         1'b1};
        vecs[5] = '{1'b0, 32'h8000_0002, 2'd1, 32'h0,         1'b1, 32'h8001_0000, 2'b00, 2, 0, 0, 0, 32'hFFFF_8001, 1'b0};
        vecs[6] = '{1'b0, 32'h8000_0000, 2'd1, 32'h0,         1'b0, 32'h1234_ABCD, 2'b00, 0, 0, 0, 2, 32'h0000_ABCD, 1'b0};
        vecs[7] = '{1'b0, 32'h8000_0000, 2'd3, 32'h0,         1'b0, 32'hCAFE_F00D, 2'b01, 0, 0, 0, 0, 32'hCAFE_F00D, 1'b1};
        vecs[8] = '{1'b1, 32'h8000_0041, 2'd0, 32'h0000_00AB, 1'b0, 32'h0,         2'b00, 0, 1, 3, 0, 32'h0,         1'b0};
`ifdef YSYX_23060061_AXIL_MISALIGN_CHECK_EN
        vecs[9] = '{1'b0, 32'h8000_0001, 2'd2, 32'h0,         1'b0, 32'h1122_3344, 2'b00, 0, 0, 0, 0, 32'h0,         1'b1};
`else
        vecs[9] = '{1'b0, 32'h8000_0001, 2'd2, 32'h0,         1'b0, 32'h1122_3344, 2'b00, 0, 0, 0, 0, 32'h0011_2233, 1'b0};
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset valids", {25'd0, arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        rst = 1;
        @(negedge clk);
        check("req_ready after reset", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            rv.wen = 1'($urandom_range(0, 1));
            rv.addr = $urandom;
            rv.size = 2'($urandom_range(0, 3));
            rv.wd = $urandom;
            rv.sgn = 1'($urandom_range(0, 1));
            rv.srd = $urandom;
            rv.sresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rv.ard = $urandom_range(0, 3);
            rv.awd = $urandom_range(0, 3);
            rv.wdly = $urandom_range(0, 3);
            rv.rdy = $urandom_range(0, 3);
            if (is_mis(rv.addr, rv.size)) begin
                rv.exp_rdata = 32'd0;
                rv.exp_err = 1'b1;
            end else begin
                rv.exp_rdata = rv.wen ? 32'd0 : load_model(rv.addr, rv.size, rv.srd, rv.sgn);
                rv.exp_err = rv.sresp != 2'b00;
            end
            run_txn(rv, $sformatf("rand%0d", i));
        end

        // Reset while waiting for read data: transaction must vanish silently.
        @(negedge clk);
        req_valid = 1; req_wen = 0; req_addr = 32'h8000_0010; req_size = 2'd2; req_signed = 0;
        @(negedge clk);
        req_valid = 0;
        arready = 1;
        @(negedge clk);
        arready = 0;
        check("midR in R", {31'd0, rready}, 32'd1);
        rst = 0;
        rvalid = 1; rdata = 32'h5555_AAAA; rresp = 2'b00;
        @(negedge clk);
        check("midR reset outputs", {26'd0, arvalid, awvalid, wvalid, rready, bready, resp_valid}, 32'd0);
        rst = 1;
        rvalid = 0;
        @(negedge clk);
        check("midR req_ready", {31'd0, req_ready}, 32'd1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid) bad++;
            @(negedge clk);
        end
        check("midR no resp", bad, 0);

        run_txn(vecs[0], "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
